// File: rtl/math_pkg.sv
// Shared constants and helpers for the math_* datapath blocks.
package math_pkg;

    // Beta term of alpha-max-plus-beta-min: 3/8 = 1/4 + 1/8.
    localparam int unsigned BETA_SHIFT_A = 2;
    localparam int unsigned BETA_SHIFT_B = 3;

    // Widest operand the abs helper accepts; narrower words are sign-extended into it.
    localparam int unsigned ABS_MAX_W = 32;

    // Unsigned absolute value. The most negative input maps to 2^(ABS_MAX_W-1) exactly.
    function automatic logic [ABS_MAX_W-1:0] abs_u(input logic signed [ABS_MAX_W-1:0] x);
        logic [ABS_MAX_W-1:0] r;
        r = x[ABS_MAX_W-1] ? ABS_MAX_W'(-x) : ABS_MAX_W'(x);
        return r;
    endfunction

endpackage

// File: rtl/math_cabs_core.sv
// Combinational magnitude estimate: abs, compare/swap, max + (min>>2) + (min>>3).
module math_cabs_core
    import math_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] dina,
    input  logic signed [WIDTH-1:0] dinb,
    output logic        [WIDTH-1:0] mag_c
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [SUM_W-1:0] sum;
    logic             unused_msb;

    // Abs values, order them, then shift-add; the sum MSB is provably zero.
    always_comb begin
        abs_a      = WIDTH'(abs_u(ABS_MAX_W'(dina)));
        abs_b      = WIDTH'(abs_u(ABS_MAX_W'(dinb)));
        mx         = abs_a;
        mn         = abs_b;
        if (abs_b > abs_a) begin
            mx = abs_b;
            mn = abs_a;
        end
        sum        = SUM_W'(mx)
                   + SUM_W'(mn >> BETA_SHIFT_A)
                   + SUM_W'(mn >> BETA_SHIFT_B);
        mag_c      = sum[WIDTH-1:0];
        unused_msb = sum[WIDTH];
    end

endmodule

// File: rtl/math_cabs.sv
// Pipelined complex-magnitude estimator, one enabled cycle of latency.
module math_cabs
    import math_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [WIDTH-1:0] dina,
    input  logic signed [WIDTH-1:0] dinb,
    output logic        [WIDTH-1:0] dout
);

    // Only the two supported word sizes are legal.
    if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
        $error("math_cabs: WIDTH must be 16 or 32");
    end

    logic [WIDTH-1:0] mag_c;

    math_cabs_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .dina  (dina),
        .dinb  (dinb),
        .mag_c (mag_c)
    );

    // Output register: cleared asynchronously, loads only on enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (ena) begin
            dout <= mag_c;
        end
    end

endmodule

// File: tb/tb_math_cabs.sv
// Self-checking bench for math_cabs at WIDTH 16 and 32.
module tb_math_cabs;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena_s;
    logic               ena_l;
    logic signed [15:0] a_s;
    logic signed [15:0] b_s;
    logic signed [31:0] a_l;
    logic signed [31:0] b_l;
    logic        [15:0] dout_s;
    logic        [31:0] dout_l;

    logic [63:0] exp_s;
    logic [63:0] exp_l;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    math_cabs #(.WIDTH(16)) u_dut_s (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena_s),
        .dina (a_s),
        .dinb (b_s),
        .dout (dout_s)
    );

    math_cabs #(.WIDTH(32)) u_dut_l (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena_l),
        .dina (a_l),
        .dinb (b_l),
        .dout (dout_l)
    );

    // Reference: max(|a|,|b|) + floor(min/4) + floor(min/8) in plain integer arithmetic.
    function automatic logic [63:0] cabs_ref(input longint a, input longint b);
        longint ua;
        longint ub;
        longint mx;
        longint mn;
        ua = (a < 0) ? -a : a;
        ub = (b < 0) ? -b : b;
        mx = (ua > ub) ? ua : ub;
        mn = (ua > ub) ? ub : ua;
        return 64'(mx + mn / 4 + mn / 8);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Advance one clock with the currently driven inputs, tracking the expected outputs.
    task automatic step();
        if (ena_s) exp_s = cabs_ref(longint'(a_s), longint'(b_s));
        if (ena_l) exp_l = cabs_ref(longint'(a_l), longint'(b_l));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_check(input string tag);
        step();
        check({tag, "_w16"}, 64'(dout_s), exp_s);
        check({tag, "_w32"}, 64'(dout_l), exp_l);
    endtask

    // Drive the same small pair into both instances with enable high.
    task automatic drive_both(input int a, input int b);
        ena_s = 1'b1;
        ena_l = 1'b1;
        a_s   = 16'(a);
        b_s   = 16'(b);
        a_l   = 32'(a);
        b_l   = 32'(b);
    endtask

    // Random word biased toward the corner values for a given width.
    function automatic logic [31:0] pick(input int unsigned w);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       r = 32'h1 << (w - 1);
            1:       r = (32'h1 << (w - 1)) - 32'h1;
            2:       r = '0;
            3:       r = '1;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int basic_a [4] = '{300, 3, 1000, 0};
        int basic_b [4] = '{400, 4, 0, -5};
        int basic_w [4] = '{512, 4, 1000, 5};

        rst   = 1'b0;
        ena_s = 1'b0;
        ena_l = 1'b0;
        a_s   = '0;
        b_s   = '0;
        a_l   = '0;
        b_l   = '0;
        exp_s = '0;
        exp_l = '0;

        // Reset state
        #1;
        check("reset_w16", 64'(dout_s), 64'd0);
        check("reset_w32", 64'(dout_l), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic values
        for (int i = 0; i < 4; i++) begin
            drive_both(basic_a[i], basic_b[i]);
            step();
            check("basic_w16", 64'(dout_s), 64'(basic_w[i]));
            check("basic_w32", 64'(dout_l), 64'(basic_w[i]));
        end

        // Sign and swap symmetry
        for (int i = 0; i < 8; i++) begin
            int pa;
            int pb;
            pa = i[0] ? -300 : 300;
            pb = i[1] ? -400 : 400;
            if (i[2]) drive_both(pb, pa);
            else      drive_both(pa, pb);
            step();
            check("symm_w16", 64'(dout_s), 64'd512);
            check("symm_w32", 64'(dout_l), 64'd512);
        end

        // Extremes: 32768+8192+4096, 32767+8191+4095, 2^31+2^29+2^28
        drive_both(-32768, -32768);
        a_l = 32'sh8000_0000;
        b_l = 32'sh8000_0000;
        step();
        check("ext_neg_w16", 64'(dout_s), 64'd45056);
        check("ext_neg_w32", 64'(dout_l), 64'd2952790016);
        drive_both(32767, 32767);
        a_l = 32'sh7fff_ffff;
        b_l = 32'sh7fff_ffff;
        step();
        check("ext_pos_w16", 64'(dout_s), 64'd45053);
        check("ext_pos_w32", 64'(dout_l), exp_l);

        // Enable hold
        drive_both(300, 400);
        step();
        check("hold_load", 64'(dout_s), 64'd512);
        drive_both(1000, 0);
        ena_s = 1'b0;
        ena_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_w16", 64'(dout_s), 64'd512);
            check("hold_w32", 64'(dout_l), 64'd512);
        end
        ena_s = 1'b1;
        ena_l = 1'b1;
        step();
        check("hold_release_w16", 64'(dout_s), 64'd1000);
        check("hold_release_w32", 64'(dout_l), 64'd1000);

        // Random stream with random enables
        for (int i = 0; i < 10000; i++) begin
            ena_s = ($urandom_range(0, 3) != 0);
            ena_l = ($urandom_range(0, 3) != 0);
            a_s   = 16'(pick(16));
            b_s   = 16'(pick(16));
            a_l   = pick(32);
            b_l   = pick(32);
            step_check("rand");
        end

        // Reset mid-stream: clears between edges and holds through enabled edges
        for (int i = 0; i < 4; i++) begin
            ena_s = 1'b1;
            ena_l = 1'b1;
            a_s   = 16'(pick(16)) | 16'h0100;
            b_s   = 16'(pick(16));
            a_l   = pick(32) | 32'h0000_0100;
            b_l   = pick(32);
            step_check("pre_rst");
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_w16", 64'(dout_s), 64'd0);
        check("rst_async_w32", 64'(dout_l), 64'd0);
        exp_s = '0;
        exp_l = '0;
        for (int i = 0; i < 3; i++) begin
            a_s = 16'(pick(16));
            a_l = pick(32);
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_w16", 64'(dout_s), 64'd0);
            check("rst_hold_w32", 64'(dout_l), 64'd0);
        end
        rst = 1'b1;
        drive_both(0, 7);
        step();
        check("post_rst_w16", 64'(dout_s), 64'd7);
        check("post_rst_w32", 64'(dout_l), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
